// File: rtl/texel_filter_unit.sv
// Texel filter unit: holds one decoded 4x4 RGBA8 texel block and answers
// bilinear sample requests against it. Each request names the top-left
// texel of a 2x2 footprint. It also carries 4-bit fractional weights.
// The right and bottom neighbours clamp to the block edge. One filtered
// texel is produced per request, and that result is held until the
// consumer takes it.
module texel_filter_unit (
  input  logic         clk,
  input  logic         rst,
  input  logic         tex_valid,
  input  logic [511:0] tex_data,
  output logic         tex_ready,
  input  logic         smp_valid,
  input  logic [1:0]   smp_x,
  input  logic [1:0]   smp_y,
  input  logic [3:0]   smp_fx,
  input  logic [3:0]   smp_fy,
  input  logic         smp_last,
  output logic         smp_ready,
  output logic         out_valid,
  output logic [31:0]  out_texel,
  input  logic         out_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOADED = 2'd1,
    CALC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [511:0]   block_q;
  logic [1:0]     sx_q, sy_q;
  logic [3:0]     sfx_q, sfy_q;
  logic           slast_q;
  logic           out_valid_q;
  logic [31:0]    out_texel_q;

  logic           tex_ready_s, smp_ready_s, busy_s;
  logic [1:0]     x1_s, y1_s;
  logic [3:0]     i00_s, i10_s, i01_s, i11_s;
  logic [31:0]    t00_s, t10_s, t01_s, t11_s;
  logic [4:0]     inv_fx_s, inv_fy_s;
  logic [8:0]     w00_s, w10_s, w01_s, w11_s;
  logic [31:0]    result_s;

  // Weighted sum of one 8-bit channel over the 2x2 footprint, rounded to nearest.
  // The weights sum to 256, so the sum never exceeds 65280 and the
  // rounded value always fits in 8 bits.
  function automatic logic [7:0] blend_ch(
    input logic [7:0] c00, input logic [7:0] c10,
    input logic [7:0] c01, input logic [7:0] c11,
    input logic [8:0] w00, input logic [8:0] w10,
    input logic [8:0] w01, input logic [8:0] w11
  );
    logic [16:0] sum;
    sum = ({9'd0, c00} * {8'd0, w00}) + ({9'd0, c10} * {8'd0, w10})
        + ({9'd0, c01} * {8'd0, w01}) + ({9'd0, c11} * {8'd0, w11});
    return 8'((sum + 17'd128) >> 8);
  endfunction

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection from the handshakes that are legal in each state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (tex_valid) state_d = LOADED;
        else           state_d = EMPTY;
      end
      LOADED: begin
        if (smp_valid) state_d = CALC;
        else           state_d = LOADED;
      end
      CALC: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = slast_q ? EMPTY : LOADED;
        else           state_d = HOLD;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Handshake readies and busy decoded directly from the current state.
  always_comb begin
    tex_ready_s = 1'b0;
    smp_ready_s = 1'b0;
    busy_s      = 1'b1;
    case (state_q)
      EMPTY: begin
        tex_ready_s = 1'b1;
        busy_s      = 1'b0;
      end
      LOADED: begin
        smp_ready_s = 1'b1;
      end
      CALC: begin
        busy_s = 1'b1;
      end
      HOLD: begin
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b1;
      end
    endcase
  end

  // Footprint addressing, texel fetch, weights and per-channel blend.
  always_comb begin
    x1_s     = (sx_q == 2'd3) ? 2'd3 : sx_q + 2'd1;
    y1_s     = (sy_q == 2'd3) ? 2'd3 : sy_q + 2'd1;
    i00_s    = {sy_q, sx_q};
    i10_s    = {sy_q, x1_s};
    i01_s    = {y1_s, sx_q};
    i11_s    = {y1_s, x1_s};
    t00_s    = block_q[{i00_s, 5'd0} +: 32];
    t10_s    = block_q[{i10_s, 5'd0} +: 32];
    t01_s    = block_q[{i01_s, 5'd0} +: 32];
    t11_s    = block_q[{i11_s, 5'd0} +: 32];
    inv_fx_s = 5'd16 - {1'b0, sfx_q};
    inv_fy_s = 5'd16 - {1'b0, sfy_q};
    w00_s    = {4'd0, inv_fx_s} * {4'd0, inv_fy_s};
    w10_s    = {5'd0, sfx_q}    * {4'd0, inv_fy_s};
    w01_s    = {4'd0, inv_fx_s} * {5'd0, sfy_q};
    w11_s    = {5'd0, sfx_q}    * {5'd0, sfy_q};
    result_s = 32'd0;
    for (int c = 0; c < 4; c++) begin
      result_s[8*c +: 8] = blend_ch(t00_s[8*c +: 8], t10_s[8*c +: 8],
                                    t01_s[8*c +: 8], t11_s[8*c +: 8],
                                    w00_s, w10_s, w01_s, w11_s);
    end
  end

  // Block capture, sample capture and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_q     <= 512'd0;
      sx_q        <= 2'd0;
      sy_q        <= 2'd0;
      sfx_q       <= 4'd0;
      sfy_q       <= 4'd0;
      slast_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_texel_q <= 32'd0;
    end else begin
      if (state_q == EMPTY && tex_valid) begin
        block_q <= tex_data;
      end
      if (state_q == LOADED && smp_valid) begin
        sx_q    <= smp_x;
        sy_q    <= smp_y;
        sfx_q   <= smp_fx;
        sfy_q   <= smp_fy;
        slast_q <= smp_last;
      end
      if (state_q == CALC) begin
        out_texel_q <= result_s;
        out_valid_q <= 1'b1;
      end else if (state_q == HOLD && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign tex_ready = tex_ready_s;
  assign smp_ready = smp_ready_s;
  assign busy      = busy_s;
  assign out_valid = out_valid_q;
  assign out_texel = out_texel_q;

endmodule

// File: doc/texel_filter_unit.md
TEXEL_FILTER_UNIT -- requirements
Module: texel_filter_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 tex_valid  in  1  decoded 4x4 texel block available from the decode stage.
REQ-005 tex_data  in  512  block; texel i = y*4+x at bits [32i+31:32i]; channel c (0..3) at bits [8c+7:8c] of a texel.
REQ-006 tex_ready  out  1  block accepted when tex_valid && tex_ready.
REQ-007 smp_valid  in  1  sample request valid.
REQ-008 smp_x, smp_y  in  2 each  top-left texel of the 2x2 footprint.
REQ-009 smp_fx, smp_fy  in  4 each  fractional weights, 0..15 in 1/16 units.
REQ-010 smp_last  in  1  release the held block after this sample.
REQ-011 smp_ready  out  1  sample accepted when smp_valid && smp_ready.
REQ-012 out_valid  out  1  filtered texel valid.
REQ-013 out_texel  out  32  filtered RGBA8 result.
REQ-014 out_ready  in  1  consumer accepts when out_valid && out_ready.
REQ-015 busy  out  1  high in every state except EMPTY.

Function
REQ-016 SHALL use FSM states EMPTY, LOADED, CALC, HOLD.
REQ-017 tex_ready = (state==EMPTY) and smp_ready = (state==LOADED); both combinational from state.
REQ-018 EMPTY: on tex_valid, capture tex_data into block register and go to LOADED; otherwise stay.
REQ-019 LOADED: on smp_valid, capture smp_x/y/fx/fy/last and go to CALC.
REQ-020 CALC: lasts exactly one cycle, registers the result into out_texel, sets out_valid=1, and goes to HOLD.
REQ-021 HOLD: out_valid and out_texel stay stable until out_ready; on out_ready, clear out_valid and go to EMPTY if the captured last=1, else LOADED.
REQ-022 Latency: a sample accepted in cycle N gives out_valid=1 in cycle N+2; minimum sample spacing is 3 cycles.
REQ-023 Neighbour coordinates: x1 = min(x+1,3) and y1 = min(y+1,3), i.e. clamp-to-edge inside the block; no wrap.
REQ-024 Weights: w00=(16-fx)(16-fy), w10=fx(16-fy), w01=(16-fx)fy, w11=fx*fy; the weights always sum to 256.
REQ-025 Per channel: sum = c00*w00 + c10*w10 + c01*w01 + c11*w11 in an unsigned 17-bit accumulator (max 65280).
REQ-026 Per channel: result = (sum+128)>>8, which never exceeds 255; no saturation logic is needed.
REQ-027 tex_valid outside EMPTY and smp_valid outside LOADED SHALL be ignored, with no state change.
REQ-028 out_ready while out_valid=0 SHALL have no effect.
REQ-029 The block register SHALL change only on an accepted block; samples reuse it until a smp_last sample completes.

Reset
REQ-030 rst SHALL force state=EMPTY, out_valid=0, out_texel=0, captured sample fields=0, block register=0.
REQ-031 After reset, tex_ready=1, smp_ready=0, busy=0.
REQ-032 Reset in any state, including mid-CALC or HOLD, SHALL abort the pending sample; no out_valid after reset.
REQ-033 Reset SHALL take priority over every simultaneous handshake.

Verification
REQ-034 Uniform block: every texel 0x11223344; samples (x,y,fx,fy)=(1,1,7,9) and (3,3,15,15) -> out_texel=0x11223344 both times.
REQ-035 Exact fetch: texel i = 0x01010101*i; sample (1,2,0,0) -> out_texel=0x09090909, out_valid exactly 2 cycles after acceptance.
REQ-036 Midpoint blend: texel0 channel0=0x00, texel1 channel0=0xFF, others 0; sample (0,0,8,0) -> channel0=0x80.
REQ-037 Edge clamp: texel3=0xAABBCCDD, texel7=0; sample (3,0,15,0) -> out_texel=0xAABBCCDD.
REQ-038 Backpressure and reset:
- Hold out_ready=0 for 5 cycles -> out_texel stable, smp_ready=0 and tex_ready=0 throughout.
- Release out_ready with smp_last=0 -> LOADED; with smp_last=1 -> EMPTY.
- Assert rst in HOLD -> next cycle out_valid=0, tex_ready=1.
